// File: rtl/pc_sequencer_if.sv
// Bundles the pipeline-facing signals of the program-counter sequencer.
// The master side is the core (hazard unit, execute stage, trap controller).
// The slave side is pc_sequencer.
interface pc_sequencer_if #(
  parameter int XLEN = 32
);
  logic            pc_stall;
  logic            jump;
  logic [XLEN-1:0] jump_target;
  logic            branch_taken;
  logic [XLEN-1:0] imm;
  logic            trapped;
  logic [XLEN-1:0] trap_target;
  logic            inst_compressed;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] next_pc;
  logic            redirect_pending;
  logic            target_misaligned;
  logic [XLEN-1:0] misaligned_addr;

  modport master (
    output pc_stall, jump, jump_target, branch_taken, imm,
           trapped, trap_target, inst_compressed,
    input  pc, next_pc, redirect_pending, target_misaligned, misaligned_addr
  );

  modport slave (
    input  pc_stall, jump, jump_target, branch_taken, imm,
           trapped, trap_target, inst_compressed,
    output pc, next_pc, redirect_pending, target_misaligned, misaligned_addr
  );
endinterface

// File: rtl/pc_sequencer.sv
// Registered program counter for the RV32 core.
// Next-PC priority is: trap, then held redirect, then jump, then branch, then
// the sequential step. A redirect that arrives while the PC is stalled is
// parked in a one-entry pending register. It is applied on the first
// unstalled edge. Jump and branch targets that are misaligned are rejected.
// A rejected target produces a one-cycle report to the trap controller.
module pc_sequencer #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              C_EXT        = 0
) (
  input logic            clk,
  input logic            reset,
  pc_sequencer_if.slave  bus
);

  // Redirect priorities, compared when a stalled request competes with a
  // redirect that is already pending.
  localparam logic [1:0] PRIO_BRANCH = 2'd0;
  localparam logic [1:0] PRIO_JUMP   = 2'd1;
  localparam logic [1:0] PRIO_TRAP   = 2'd2;

  localparam bit HAS_C = (C_EXT != 0);

  // Architectural state
  logic [XLEN-1:0] r_pc;
  logic            r_pend_valid;
  logic [1:0]      r_pend_prio;
  logic [XLEN-1:0] r_pend_target;
  logic            r_mis;
  logic [XLEN-1:0] r_mis_addr;

  // Next-state values
  logic [XLEN-1:0] w_pc_next;
  logic            w_pend_valid_next;
  logic [1:0]      w_pend_prio_next;
  logic [XLEN-1:0] w_pend_target_next;
  logic            w_mis_next;
  logic [XLEN-1:0] w_mis_addr_next;

  // Candidate addresses
  logic [XLEN-1:0] w_step;
  logic [XLEN-1:0] w_seq_pc;
  logic [XLEN-1:0] w_trap_tgt;
  logic [XLEN-1:0] w_jump_tgt;
  logic [XLEN-1:0] w_branch_tgt;
  logic            w_jump_mis;
  logic            w_branch_mis;

  // The request seen this cycle, after alignment filtering
  logic            w_req_valid;
  logic [1:0]      w_req_prio;
  logic [XLEN-1:0] w_req_target;
  logic            w_req_mis;
  logic [XLEN-1:0] w_req_mis_addr;

  // A 16-bit step only exists when compressed support is built in.
  assign w_step = (HAS_C && bus.inst_compressed) ? XLEN'(2) : XLEN'(4);
  assign w_seq_pc = r_pc + w_step;

  // The trap base is always word-aligned. The JALR rule clears bit 0 of a
  // jump target, so a jump can only be misaligned through bit 1.
  assign w_trap_tgt   = bus.trap_target & ~XLEN'(3);
  assign w_jump_tgt   = bus.jump_target & ~XLEN'(1);
  assign w_branch_tgt = r_pc + bus.imm;

  assign w_jump_mis   = !HAS_C && w_jump_tgt[1];
  assign w_branch_mis = w_branch_tgt[0] || (!HAS_C && w_branch_tgt[1]);

  // Decode this cycle's request. A trap masks jump and branch completely,
  // including their alignment check. A misaligned jump or branch becomes a
  // report rather than a redirect.
  always_comb begin
    w_req_valid    = 1'b0;
    w_req_prio     = PRIO_BRANCH;
    w_req_target   = w_seq_pc;
    w_req_mis      = 1'b0;
    w_req_mis_addr = '0;
    if (bus.trapped) begin
      w_req_valid  = 1'b1;
      w_req_prio   = PRIO_TRAP;
      w_req_target = w_trap_tgt;
    end else if (bus.jump) begin
      if (w_jump_mis) begin
        w_req_mis      = 1'b1;
        w_req_mis_addr = w_jump_tgt;
      end else begin
        w_req_valid  = 1'b1;
        w_req_prio   = PRIO_JUMP;
        w_req_target = w_jump_tgt;
      end
    end else if (bus.branch_taken) begin
      if (w_branch_mis) begin
        w_req_mis      = 1'b1;
        w_req_mis_addr = w_branch_tgt;
      end else begin
        w_req_valid  = 1'b1;
        w_req_prio   = PRIO_BRANCH;
        w_req_target = w_branch_tgt;
      end
    end
  end

  // Next-PC selection and pending-redirect bookkeeping.
  always_comb begin
    w_pc_next          = r_pc;
    w_pend_valid_next  = r_pend_valid;
    w_pend_prio_next   = r_pend_prio;
    w_pend_target_next = r_pend_target;
    w_mis_next         = w_req_mis;
    w_mis_addr_next    = w_req_mis ? w_req_mis_addr : r_mis_addr;
    if (bus.pc_stall) begin
      // The PC holds. A request is parked if nothing is pending, or if it
      // ranks at least as high as the parked one (a newer request wins a tie).
      if (w_req_valid && (!r_pend_valid || (w_req_prio >= r_pend_prio))) begin
        w_pend_valid_next  = 1'b1;
        w_pend_prio_next   = w_req_prio;
        w_pend_target_next = w_req_target;
      end
    end else begin
      // Any unstalled edge either consumes the pending redirect or overrides
      // it with a trap, so pending always empties here.
      w_pend_valid_next = 1'b0;
      if (bus.trapped) begin
        w_pc_next = w_trap_tgt;
      end else if (r_pend_valid) begin
        w_pc_next = r_pend_target;
      end else if (w_req_valid) begin
        w_pc_next = w_req_target;
      end else begin
        w_pc_next = w_seq_pc;
      end
    end
  end

  // State register. Reset discards every held redirect and report.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc          <= RESET_VECTOR;
      r_pend_valid  <= 1'b0;
      r_pend_prio   <= PRIO_BRANCH;
      r_pend_target <= '0;
      r_mis         <= 1'b0;
      r_mis_addr    <= '0;
    end else begin
      r_pc          <= w_pc_next;
      r_pend_valid  <= w_pend_valid_next;
      r_pend_prio   <= w_pend_prio_next;
      r_pend_target <= w_pend_target_next;
      r_mis         <= w_mis_next;
      r_mis_addr    <= w_mis_addr_next;
    end
  end

  assign bus.pc                = r_pc;
  assign bus.next_pc           = w_pc_next;
  assign bus.redirect_pending  = r_pend_valid;
  assign bus.target_misaligned = r_mis;
  assign bus.misaligned_addr   = r_mis_addr;

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Registered program-counter unit for the RV32 core; the successor of the combinational next-PC selector.
- Holds the architectural PC and selects the next PC by priority: trap > jump > branch > sequential.
- Remembers a redirect that arrives during a stall and applies it when the stall releases.
- Adds XLEN/reset-vector parametrisation, optional compressed-instruction stepping, and misaligned-target detection feeding the trap controller.

Parameters:
- XLEN, 32, width of PC and all address ports.
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
- C_EXT, 0, 1 = 2-byte instruction alignment and 16-bit step allowed; 0 = 4-byte only.

Ports:
- clk  in  1  core clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- pc_stall  in  1  hold PC this cycle.
- jump  in  1  jump (JAL/JALR) request.
- jump_target  in  XLEN  absolute jump target.
- branch_taken  in  1  conditional branch resolved taken.
- imm  in  XLEN  branch offset, sign-extended, relative to current pc.
- trapped  in  1  trap/exception entry request.
- trap_target  in  XLEN  trap handler address (mtvec-derived).
- inst_compressed  in  1  current instruction is 16-bit; ignored when C_EXT=0.
- pc  out  XLEN  current PC (registered).
- next_pc  out  XLEN  value pc takes at next edge (combinational).
- redirect_pending  out  1  a stalled redirect is held.
- target_misaligned  out  1  one-cycle pulse: rejected jump/branch target.
- misaligned_addr  out  XLEN  offending target, valid with target_misaligned.

Behaviour:
- Reset (async): pc=RESET_VECTOR, pending cleared, redirect_pending=0, target_misaligned=0, misaligned_addr=0.
- Sequential step: pc + 4, or pc + 2 when C_EXT=1 and inst_compressed=1.
- Address arithmetic is modulo 2^XLEN; wrap-around is silent.
- Target formation:
  - Trap: trap_target with bits[1:0] forced to 0.
  - Jump: jump_target with bit0 forced to 0 (JALR semantics).
  - Branch: pc + imm.
- Alignment check applies to jump and branch targets only; traps are never checked.
  - Misaligned when bit1 is set and C_EXT=0.
  - Branch bit0 set is misaligned in any mode.
- Misaligned jump/branch, evaluated in the cycle of the request:
  - No redirect; pc advances sequentially (or holds if stalled).
  - Next edge: target_misaligned=1 and misaligned_addr=target, for exactly one cycle.
  - Trap controller is expected to raise trapped afterwards.
- Selection in a non-stalled cycle, first match wins:
  1. trapped
  2. pending redirect
  3. jump (aligned)
  4. branch_taken (aligned)
  5. sequential step
- Applying a target clears pending; next_pc reflects the selected value combinationally.
- Stalled cycle (pc_stall=1): pc holds; next_pc=pc.
  - Any valid redirect request is captured into the pending register; redirect_pending=1 from the next edge.
  - Pending replacement: a new request overwrites pending only if its priority is >= the pending one (trap=2, jump=1, branch=0). Equal priority: newer wins.
  - Stall with no request: pending is unchanged.
- Stall release with pending held: pc <= pending target on the first unstalled edge; redirect_pending falls the same edge.
  - A trap in that cycle overrides pending; pending is cleared.
- Simultaneous trapped with jump/branch: trap wins; jump/branch is dropped and gets no misalignment check.
- Reset mid-stall or with pending held: all state discarded; pc=RESET_VECTOR.

Test Plan:
- Reset release, no requests, C_EXT=0: pc 0→4→8→C on successive edges; redirect_pending=0.
- pc=0x1000, jump=1, jump_target=0xDEAD0001: next_pc=0xDEAD0000; next edge pc=0xDEAD0000.
- pc=0x2000, branch_taken=1, imm=0xFFFFFFF0: pc becomes 0x1FF0. Then imm=0x0000BEEE with C_EXT=0: no redirect, pc=0x1FF4, target_misaligned pulses with addr 0x0000DEDE.
- pc_stall=1 at pc=0x100 with jump to 0x400, then branch (imm=0x10) while still stalled: pending stays 0x400, redirect_pending=1. Stall released: pc=0x400, redirect_pending=0.
- Stalled with pending jump 0x400, then trapped=1 with trap_target=0xCAFEBABE while still stalled: pending replaced. On release pc=0xCAFEBABC.
- C_EXT=1 at pc=0xFFFFFFFE, inst_compressed=1: pc wraps to 0x0. Assert reset while pending held: pc=RESET_VECTOR, redirect_pending=0 immediately.
